avm_alu_master: RTL and testbench



---
 rtl/avm_alu_master.sv | 210 +++++++++++++++++++++
 tb/tb_avm_alu_master.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/avm_alu_master.sv
// Avalon-MM master that runs one ALU job per command: write A, write B, write opcode, read result.
// Optional waitrequest timeout enabled by defining AVM_ALU_MASTER_TIMEOUT_EN.
module avm_alu_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int OP_W           = 2,
  parameter int ADDR_A         = 0,
  parameter int ADDR_B         = 1,
  parameter int ADDR_OP        = 3,
  parameter int ADDR_RES       = 0,
  parameter int READ_LATENCY   = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [OP_W-1:0]   cmd_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] avm_address,
  output logic [DATA_W-1:0] avm_write_data,
  output logic              avm_write,
  output logic              avm_read,
  input  logic [DATA_W-1:0] avm_read_data,
  input  logic              avm_waitrequest
);

  if (READ_LATENCY < 1 || READ_LATENCY > 15 || TIMEOUT_CYCLES < 1 || OP_W > DATA_W) begin : g_bad_params
    $error("avm_alu_master: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_A    = 3'd1,
    WR_B    = 3'd2,
    WR_OP   = 3'd3,
    RD_REQ  = 3'd4,
    RD_WAIT = 3'd5,
    RESP    = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [3:0]        lat_q, lat_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;
  logic              read_q, read_d;
  logic              timeout;

`ifdef AVM_ALU_MASTER_TIMEOUT_EN
  localparam int TO_W = 16;

  logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            rsp_error_q, rsp_error_d;
  logic            in_bus_state;

  // Counts consecutive stalled cycles of the current bus request; fires on the last allowed one.
  always_comb begin
    in_bus_state = (state_q == WR_A) || (state_q == WR_B) || (state_q == WR_OP) || (state_q == RD_REQ);
    wait_cnt_d   = '0;
    timeout      = 1'b0;
    if (in_bus_state && avm_waitrequest) begin
      if (wait_cnt_q >= TO_W'(TIMEOUT_CYCLES - 1)) begin
        timeout = 1'b1;
      end else begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end
    rsp_error_d = rsp_error_q;
    if (timeout) begin
      rsp_error_d = 1'b1;
    end else if (state_q == RESP && rsp_ready) begin
      rsp_error_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q  <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign rsp_error = rsp_error_q;
`else
  assign timeout   = 1'b0;
  assign rsp_error = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    lat_d       = lat_q;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          a_d     = cmd_a;
          b_d     = cmd_b;
          op_d    = cmd_op;
          state_d = WR_A;
        end
      end
      WR_A:   if (!avm_waitrequest) state_d = WR_B;
      WR_B:   if (!avm_waitrequest) state_d = WR_OP;
      WR_OP:  if (!avm_waitrequest) state_d = RD_REQ;
      RD_REQ: begin
        if (!avm_waitrequest) begin
          lat_d   = 4'(READ_LATENCY - 1);
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (lat_q == 4'd0) begin
          rsp_data_d = avm_read_data;
          state_d    = RESP;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      rsp_data_d = '0;
      state_d    = RESP;
    end

    // Outputs are registered copies decoded from the next state, so nothing combinational reaches a port.
    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    write_d     = (state_d == WR_A) || (state_d == WR_B) || (state_d == WR_OP);
    read_d      = (state_d == RD_REQ);
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    case (state_d)
      WR_A: begin
        addr_d  = ADDR_W'(ADDR_A);
        wdata_d = a_d;
      end
      WR_B: begin
        addr_d  = ADDR_W'(ADDR_B);
        wdata_d = b_q;
      end
      WR_OP: begin
        addr_d  = ADDR_W'(ADDR_OP);
        wdata_d = DATA_W'(op_q);
      end
      RD_REQ:  addr_d = ADDR_W'(ADDR_RES);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      lat_q       <= '0;
      rsp_data_q  <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      read_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      lat_q       <= lat_d;
      rsp_data_q  <= rsp_data_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      read_q      <= read_d;
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign avm_address    = addr_q;
  assign avm_write_data = wdata_q;
  assign avm_write      = write_q;
  assign avm_read       = read_q;

endmodule

// File: tb/tb_avm_alu_master.sv
// Directed bench for avm_alu_master: slave model, bus-op and response scoreboards.
`timescale 1ns/1ps
module tb_avm_alu_master;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] want);
    checks++;
    if (obs !== want) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // DUT with READ_LATENCY=1
  logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_error;
  logic [31:0] cmd_a, cmd_b, rsp_data;
  logic [1:0]  cmd_op;
  logic [31:0] avm_address, avm_write_data, avm_read_data;
  logic        avm_write, avm_read, avm_waitrequest;

  // DUT with READ_LATENCY=3
  logic        cmd_valid3, cmd_ready3, rsp_valid3, rsp_ready3, rsp_error3;
  logic [31:0] cmd_a3, cmd_b3, rsp_data3;
  logic [1:0]  cmd_op3;
  logic [31:0] avm_address3, avm_write_data3, avm_read_data3;
  logic        avm_write3, avm_read3, avm_waitrequest3;

  avm_alu_master #(.READ_LATENCY(1), .TIMEOUT_CYCLES(8)) dut1 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .avm_address(avm_address), .avm_write_data(avm_write_data), .avm_write(avm_write),
    .avm_read(avm_read), .avm_read_data(avm_read_data), .avm_waitrequest(avm_waitrequest)
  );

  avm_alu_master #(.READ_LATENCY(3), .TIMEOUT_CYCLES(8)) dut3 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_a(cmd_a3), .cmd_b(cmd_b3), .cmd_op(cmd_op3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3), .rsp_error(rsp_error3),
    .avm_address(avm_address3), .avm_write_data(avm_write_data3), .avm_write(avm_write3),
    .avm_read(avm_read3), .avm_read_data(avm_read_data3), .avm_waitrequest(avm_waitrequest3)
  );

  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a - b;
      2'd2:    return a + b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic logic [64:0] bop(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    return {wr, addr, data};
  endfunction

  // Register-file slave for dut1, one-cycle read latency
  logic [31:0] reg_a = 32'd0, reg_b = 32'd0;
  logic [1:0]  reg_op = 2'd0;
  logic        rd_pend = 1'b0;
  always @(posedge clk) begin
    if (avm_write === 1'b1 && avm_waitrequest == 1'b0) begin
      case (avm_address)
        32'd0:   reg_a  <= avm_write_data;
        32'd1:   reg_b  <= avm_write_data;
        32'd3:   reg_op <= avm_write_data[1:0];
        default: ;
      endcase
    end
    rd_pend <= (avm_read === 1'b1) && !avm_waitrequest && (avm_address == 32'd0);
  end
  assign avm_read_data = rd_pend ? alu(reg_a, reg_b, reg_op) : 32'hDEAD_BEEF;

  // Three-cycle slave for dut3; a decoy value sits on the bus one cycle before the real one
  logic [2:0] pipe3 = 3'd0;
  always @(posedge clk) pipe3 <= {pipe3[1:0], (avm_read3 === 1'b1) && !avm_waitrequest3};
  assign avm_read_data3 = pipe3[2] ? 32'd22 : (pipe3[1] ? 32'd99 : 32'hDEAD_BEEF);

  logic [64:0] bus_q[$];
  logic [32:0] rsp_q[$];

  // Bus monitor for dut1: every accepted transfer must match the next expected op
  always @(negedge clk) begin
    if (!rst && (avm_write || avm_read)) begin
      chk("strobe_excl", avm_write & avm_read, 1'b0);
      if (!avm_waitrequest) begin
        chk("bus_q_nonempty", bus_q.size() != 0, 1'b1);
        if (bus_q.size() != 0) begin
          chk("bus_op", bop(avm_write, avm_address, avm_write ? avm_write_data : 32'd0), bus_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    bus_q.push_back(bop(1'b1, 32'd0, a));
    bus_q.push_back(bop(1'b1, 32'd1, b));
    bus_q.push_back(bop(1'b1, 32'd3, {30'd0, op}));
    bus_q.push_back(bop(1'b0, 32'd0, 32'd0));
    rsp_q.push_back({1'b0, alu(a, b, op)});
  endtask

  // Returns one cycle after the command handshake
  task automatic send1(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    int n = 0;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    chk("cmd_ready_wait", cmd_ready, 1'b1);
    push_exp(a, b, op);
    step();
    cmd_valid = 1'b0;
  endtask

  // Waits for rsp_valid counting from handshake+1; stalls the WR_B write for 'stall' cycles
  task automatic wait_rsp(input int stall, input logic [31:0] b, input int exp_lat);
    int c = 1;
    while (!rsp_valid && c < 60) begin
      step();
      c++;
      avm_waitrequest = (c >= 2 && c < 2 + stall);
      if (c >= 2 && c <= 2 + stall) begin
        chk("wr_b_hold", {avm_write, avm_read, avm_address, avm_write_data}, {1'b1, 1'b0, 32'd1, b});
      end
    end
    chk("rsp_latency", c, exp_lat);
  endtask

  task automatic take_rsp();
    logic [32:0] e;
    e = (rsp_q.size() != 0) ? rsp_q.pop_front() : 33'h1_FFFF_FFFF;
    chk("rsp", {rsp_valid, rsp_error, rsp_data}, {1'b1, e});
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_done_idle", {rsp_valid, cmd_ready}, 2'b01);
  endtask

  task automatic run1(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                      input int stall, input int exp_lat);
    send1(a, b, op);
    wait_rsp(stall, b, exp_lat);
    take_rsp();
  endtask

  initial begin
    int c;
    int n;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; rsp_ready = 1'b0; avm_waitrequest = 1'b0;
    cmd_valid3 = 1'b0; cmd_a3 = '0; cmd_b3 = '0; cmd_op3 = '0; rsp_ready3 = 1'b0; avm_waitrequest3 = 1'b0;
    step();
    step();
    chk("reset_outputs", {cmd_ready, rsp_valid, rsp_data, rsp_error, avm_address, avm_write_data, avm_write, avm_read}, 102'd0);
    chk("reset_outputs3", {cmd_ready3, rsp_valid3, rsp_error3, avm_write3, avm_read3}, 5'd0);
    rst = 1'b0;
    step();
    chk("cmd_ready_after_rst", {cmd_ready, cmd_ready3}, 2'b11);

    // Basic job, no waitrequest
    run1(32'd42, 32'd20, 2'd2, 0, 6);
    // Same job, WR_B stalled three cycles
    run1(32'd42, 32'd20, 2'd2, 3, 9);
    // Another pattern, one stall cycle
    run1(32'hF0F0_1234, 32'h0FF0_FFFF, 2'd3, 1, 7);

    // READ_LATENCY=3 instance
    cmd_a3 = 32'd42; cmd_b3 = 32'd20; cmd_op3 = 2'd1; cmd_valid3 = 1'b1;
    chk("cmd_ready3", cmd_ready3, 1'b1);
    step();
    cmd_valid3 = 1'b0;
    c = 1;
    while (!rsp_valid3 && c < 60) begin
      step();
      c++;
    end
    chk("rsp_latency3", c, 8);
    chk("rsp3", {rsp_valid3, rsp_error3, rsp_data3}, {1'b1, 1'b0, 32'd22});
    rsp_ready3 = 1'b1;
    step();
    rsp_ready3 = 1'b0;
    chk("rsp3_done", {rsp_valid3, cmd_ready3}, 2'b01);

    // Two queued commands, first response stalled five cycles
    send1(32'h1234_5678, 32'h0000_FFFF, 2'd0);
    cmd_a = 32'd100; cmd_b = 32'd58; cmd_op = 2'd1; cmd_valid = 1'b1;
    wait_rsp(0, 32'h0000_FFFF, 6);
    for (int i = 0; i < 5; i++) begin
      chk("stall_hold", {rsp_valid, rsp_error, rsp_data, avm_write, avm_read, cmd_ready}, {1'b1, rsp_q[0], 3'b000});
      step();
    end
    take_rsp();
    push_exp(32'd100, 32'd58, 2'd1);
    step();
    cmd_valid = 1'b0;
    chk("second_wr_a", {avm_write, avm_address, avm_write_data}, {1'b1, 32'd0, 32'd100});
    wait_rsp(0, 32'd58, 6);
    take_rsp();

    // Reset pulsed while the opcode write is on the bus
    send1(32'd7, 32'd9, 2'd2);
    step();
    step();
    chk("wr_op_active", {avm_write, avm_address, avm_write_data}, {1'b1, 32'd3, 32'd2});
    rst = 1'b1;
    step();
    chk("rst_mid_strobes", {avm_write, avm_read, cmd_ready, rsp_valid}, 4'd0);
    rst = 1'b0;
    bus_q.delete();
    rsp_q.delete();
    step();
    chk("rst_mid_ready", cmd_ready, 1'b1);
    for (int i = 0; i < 10; i++) begin
      chk("rst_no_rsp", {rsp_valid, avm_write, avm_read}, 3'd0);
      step();
    end
    run1(32'd5, 32'd3, 2'd1, 0, 6);

`ifdef AVM_ALU_MASTER_TIMEOUT_EN
    // Stuck waitrequest on the result read
    send1(32'd11, 32'd22, 2'd2);
    void'(rsp_q.pop_back());
    rsp_q.push_back({1'b1, 32'd0});
    c = 1;
    while (!avm_read && c < 20) begin
      step();
      c++;
    end
    chk("to_rd_req_cycle", c, 4);
    avm_waitrequest = 1'b1;
    n = 0;
    while (avm_read && n < 40) begin
      n++;
      step();
    end
    chk("to_read_cycles", n, 8);
    take_rsp();
    avm_waitrequest = 1'b0;
    bus_q.delete();
    run1(32'd1, 32'd2, 2'd2, 0, 6);
`endif

    step();
    chk("bus_q_empty", bus_q.size(), 0);
    chk("rsp_q_empty", rsp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
